uart_rx_param: RTL and testbench
================================

# uart_rx_param

Parametrised UART receive subsystem: an internal baud-tick generator, an oversampling receiver with configurable data width, parity and stop bits, and a receive FIFO, all in one block. Each received frame is stored with its framing- and parity-error status, and a sticky overrun flag reports frames dropped because the FIFO was full. It sits between the `rx` pad and the host read interface, replacing the fixed 8-bit receive path.

## Interface
- `DATA_BITS`, 8: data bits per frame. Legal range 5..9.
- `OS`, 16: baud ticks per bit. Even, ≥ 4.
- `STOP_BITS`, 1: stop bits checked per frame, 1 or 2.
- `PARITY_EN`, 0: 1 means a parity bit follows the data bits.
- `DIV_W`, 10: width of `baud_div`.
- `DEPTH`, 8: FIFO entries. Power of two, ≥ 2.

Ports:
- `clk`  in  1: the single clock.
- `rst`  in  1: reset, asynchronous, active-low.
- `rx`  in  1: serial line, asynchronous, idles high.
- `baud_div`  in  DIV_W: one tick every `baud_div`+1 clocks.
- `parity_odd`  in  1: 0 = even parity, 1 = odd parity. Ignored if `PARITY_EN`=0.
- `read_en`  in  1: pop the FIFO head.
- `clr_overrun`  in  1: clear `overrun`.
- `read_data`  out  DATA_BITS: data of the FIFO head.
- `read_frame_err`  out  1: framing-error bit of the head entry.
- `read_parity_err`  out  1: parity-error bit of the head entry.
- `empty`  out  1: FIFO empty.
- `full`  out  1: FIFO full.
- `count`  out  $clog2(DEPTH)+1: FIFO occupancy.
- `overrun`  out  1: sticky; a frame was dropped.
- `rx_busy`  out  1: receiver is not in IDLE.

## Operation
- **Reset** (`rst`=0, asynchronous): FSM goes to IDLE; all counters and pointers are cleared.
  - Reset values: `empty`=1, `full`=0, `count`=0, `overrun`=0, `rx_busy`=0, `read_data`/`read_frame_err`/`read_parity_err`=0.
  - A frame in progress when reset asserts is discarded.
- **Input synchroniser**: `rx` passes through two flops, reset value 1. All sampling uses the synchronised signal `rxs`.
- **Baud generator**: counter runs 0..`baud_div` and pulses `tick` for one clock when it equals `baud_div`, then wraps to 0.
  - The counter runs freely and is never restarted by frame activity.
  - `baud_div`=0 gives a tick every clock.
- **FSM states**: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE. Tick counter `t` (0..OS-1), bit counter `n`.
  - IDLE: when `rxs`=0, go to START with `t`=0.
  - START: on the tick where `t`=OS/2-1, re-check `rxs`.
    - If `rxs`=0, go to DATA with `t`=0, `n`=0.
    - If `rxs`=1, treat it as a glitch and return to IDLE. Nothing is stored.
  - DATA: on each tick where `t`=OS-1, sample `rxs` into the shift register, LSB first.
    - After DATA_BITS samples, go to PARITY if `PARITY_EN`=1, otherwise to STOP.
  - PARITY: sample once at `t`=OS-1.
    - `perr` = XOR of all data bits, XOR the parity bit, XOR `parity_odd`. A nonzero result is an error.
  - STOP: sample at `t`=OS-1, `STOP_BITS` times. `ferr`=1 if any stop sample is 0.
    - After the last stop sample, push `{ferr, perr, data}` into the FIFO.
    - Then go to IDLE if the last stop sample was 1, otherwise to WAIT_IDLE.
  - WAIT_IDLE (break or bad line): stay until `rxs`=1, then go to IDLE. No start is detected while here.
- **Push rules**:
  - A frame is pushed whether or not it has errors. `perr` is 0 when `PARITY_EN`=0.
  - If the FIFO is full at push time and `read_en` is not asserted in that cycle, the frame is dropped, `overrun` is set, and FIFO contents are unchanged.
  - Full FIFO with push and `read_en` in the same cycle: both happen and `count` stays at DEPTH.
- **FIFO**: first-word fall-through.
  - `read_*` outputs show the head entry whenever `empty`=0. They hold their last value when empty.
  - `read_en` with `empty`=1 is ignored.
  - Pointers wrap modulo DEPTH.
  - `full` = (`count`==DEPTH), `empty` = (`count`==0).
- **`overrun`**: cleared by `clr_overrun`. If `clr_overrun` and a new drop occur in the same cycle, the set wins.

## Timing
- `rx` to `rxs`: 2 clocks.
- Falling edge on `rx` to START entry: 3 clocks.
- Data samples are taken about mid-bit, OS/2 + k·OS ticks after the start is detected, with ±1 tick jitter from the free-running divider.
- FIFO write happens on the clock edge after the final stop-sample tick. `empty`, `count` and `read_*` update on that same edge.
- Pop: `read_en` sampled high at an edge advances the head. New `read_*` values and `count` are visible after that edge.
- `rx_busy` is 1 from START entry until IDLE is re-entered, including WAIT_IDLE.
- Back-to-back frames: a new start bit may begin immediately after the last stop bit with no idle gap.

## Test plan
- **Clean frame**: `baud_div`=3, OS=16 (64 clk/bit), send 0xA5 with 1 stop bit. Required: one entry, `read_data`=0xA5, both error bits 0, then `read_en` gives `empty`=1.
- **Parity**: `PARITY_EN`=1, `parity_odd`=0.
  - 0x03 sent with parity bit 0: `read_parity_err`=0.
  - 0x03 sent with parity bit 1: `read_parity_err`=1.
- **Framing**: send 0x5A with stop bit 0, then hold `rx` low for 3 bit times, then release.
  - Required: one entry with `read_data`=0x5A and `read_frame_err`=1.
  - `rx_busy` stays 1 until `rx` goes high; no second entry is created.
- **Glitch**: drive `rx` low for 5 ticks (20 clk) only. Required: no entry, `rx_busy` returns to 0, `empty` stays 1.
- **Overrun**: DEPTH=8, send bytes 0x01..0x09 with no reads.
  - Required: `count`=8, `full`=1, `overrun`=1; reading out gives 0x01..0x08 in order.
  - `clr_overrun` then gives `overrun`=0.
- **Reset mid-frame**: assert `rst` during DATA of 0xFF, release, then send 0x3C.
  - Required: all outputs at reset values immediately; the only entry afterwards is 0x3C.

Source files
------------

// File: rtl/uart_rx_param.sv
// UART receive subsystem: free-running baud divider, oversampling receiver
// with optional parity and 1/2 stop bits, and a first-word fall-through FIFO.
module uart_rx_param #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned OS        = 16,
  parameter int unsigned STOP_BITS = 1,
  parameter int unsigned PARITY_EN = 0,
  parameter int unsigned DIV_W     = 10,
  parameter int unsigned DEPTH     = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rx,
  input  logic [DIV_W-1:0]         baud_div,
  input  logic                     parity_odd,
  input  logic                     read_en,
  input  logic                     clr_overrun,
  output logic [DATA_BITS-1:0]     read_data,
  output logic                     read_frame_err,
  output logic                     read_parity_err,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overrun,
  output logic                     rx_busy
);

  localparam int unsigned TW = $clog2(OS);
  localparam int unsigned NW = $clog2(DATA_BITS + 1);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned EW = DATA_BITS + 2;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;

  logic             rx_m, rxs;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;

  state_t                state, state_n;
  logic [TW-1:0]         t, t_n;
  logic [NW-1:0]         n, n_n;
  logic [DATA_BITS-1:0]  shreg, shreg_n;
  logic                  perr, perr_n, ferr, ferr_n;
  logic                  t_end, push;
  logic [EW-1:0]         wdata;

  logic [EW-1:0] mem [DEPTH];
  logic [EW-1:0] head_q;
  logic [PW-1:0] rd_ptr, wr_ptr, rd_nxt;
  logic          do_pop, push_ok, drop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_m <= 1'b1;
      rxs  <= 1'b1;
    end else begin
      rx_m <= rx;
      rxs  <= rx_m;
    end
  end

  assign tick = (div_cnt == baud_div);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      t     <= '0;
      n     <= '0;
      shreg <= '0;
      perr  <= 1'b0;
      ferr  <= 1'b0;
    end else begin
      state <= state_n;
      t     <= t_n;
      n     <= n_n;
      shreg <= shreg_n;
      perr  <= perr_n;
      ferr  <= ferr_n;
    end
  end

  assign t_end = (t == TW'(OS - 1));
  // Pushed entry folds in the stop sample taken in the same cycle.
  assign wdata = {ferr | ~rxs, perr, shreg};

  always_comb begin
    state_n = state;
    t_n     = t;
    n_n     = n;
    shreg_n = shreg;
    perr_n  = perr;
    ferr_n  = ferr;
    push    = 1'b0;
    case (state)
      IDLE: if (!rxs) begin
        state_n = START;
        t_n     = '0;
      end
      START: if (tick) begin
        if (t == TW'(OS / 2 - 1)) begin
          t_n = '0;
          n_n = '0;
          state_n = rxs ? IDLE : DATA;
        end else begin
          t_n = t + 1'b1;
        end
      end
      DATA: if (tick) begin
        t_n = t_end ? '0 : t + 1'b1;
        if (t_end) begin
          shreg_n = {rxs, shreg[DATA_BITS-1:1]};
          if (n == NW'(DATA_BITS - 1)) begin
            n_n     = '0;
            perr_n  = 1'b0;
            ferr_n  = 1'b0;
            state_n = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            n_n = n + 1'b1;
          end
        end
      end
      PARITY: if (tick) begin
        t_n = t_end ? '0 : t + 1'b1;
        if (t_end) begin
          perr_n  = (^shreg) ^ rxs ^ parity_odd;
          state_n = STOP;
        end
      end
      STOP: if (tick) begin
        t_n = t_end ? '0 : t + 1'b1;
        if (t_end) begin
          ferr_n = ferr | ~rxs;
          if (n == NW'(STOP_BITS - 1)) begin
            push    = 1'b1;
            state_n = rxs ? IDLE : WAIT_IDLE;
          end else begin
            n_n = n + 1'b1;
          end
        end
      end
      WAIT_IDLE: if (rxs) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign rx_busy = (state != IDLE);

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = read_en & ~empty;
  assign push_ok = push & (~full | do_pop);
  assign drop    = push & full & ~do_pop;
  assign rd_nxt  = rd_ptr + 1'b1;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_pop)  rd_ptr <= rd_nxt;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      case ({push_ok, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Registered head keeps the last value visible once the FIFO drains;
  // the incoming word bypasses memory when it becomes the new head.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q <= '0;
    end else if (push_ok && (empty || (do_pop && count == CW'(1)))) begin
      head_q <= wdata;
    end else if (do_pop && count > CW'(1)) begin
      head_q <= mem[rd_nxt];
    end
  end

  assign {read_frame_err, read_parity_err, read_data} = head_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)             overrun <= 1'b0;
    else if (drop)        overrun <= 1'b1;
    else if (clr_overrun) overrun <= 1'b0;
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: one instance without parity, one with.
module tb_uart_rx_param;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [9:0] baud_div;
  logic       parity_odd;

  logic       rx_a, rd_a, clr_a;
  logic [7:0] a_data;
  logic       a_ferr, a_perr, a_empty, a_full, a_ovr, a_busy;
  logic [3:0] a_count;

  logic       rx_p, rd_p, clr_p;
  logic [7:0] p_data;
  logic       p_ferr, p_perr, p_empty, p_full, p_ovr, p_busy;
  logic [3:0] p_count;

  uart_rx_param #(.DATA_BITS(8), .OS(16), .STOP_BITS(1), .PARITY_EN(0),
                  .DIV_W(10), .DEPTH(8)) u_dut (
    .clk(clk), .rst(rst), .rx(rx_a), .baud_div(baud_div), .parity_odd(parity_odd),
    .read_en(rd_a), .clr_overrun(clr_a), .read_data(a_data),
    .read_frame_err(a_ferr), .read_parity_err(a_perr), .empty(a_empty),
    .full(a_full), .count(a_count), .overrun(a_ovr), .rx_busy(a_busy));

  uart_rx_param #(.DATA_BITS(8), .OS(16), .STOP_BITS(1), .PARITY_EN(1),
                  .DIV_W(10), .DEPTH(8)) u_par (
    .clk(clk), .rst(rst), .rx(rx_p), .baud_div(baud_div), .parity_odd(parity_odd),
    .read_en(rd_p), .clr_overrun(clr_p), .read_data(p_data),
    .read_frame_err(p_ferr), .read_parity_err(p_perr), .empty(p_empty),
    .full(p_full), .count(p_count), .overrun(p_ovr), .rx_busy(p_busy));

  int checks   = 0;
  int failures = 0;

  typedef struct {
    bit         par;
    logic [7:0] data;
    logic       pbit;
    logic       odd;
    logic [7:0] exp_data;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic tk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_rx(input bit par, input logic b);
    if (par) rx_p = b;
    else     rx_a = b;
  endtask

  // 64 clocks per bit (baud_div=3, OS=16); line is left at the stop level.
  task automatic send_frame(input bit par, input logic [7:0] d, input logic pbit, input logic sbit);
    set_rx(par, 1'b0);
    tk(64);
    for (int i = 0; i < 8; i++) begin
      set_rx(par, d[i]);
      tk(64);
    end
    if (par) begin
      set_rx(par, pbit);
      tk(64);
    end
    set_rx(par, sbit);
    tk(64);
  endtask

  task automatic pop(input bit par);
    if (par) rd_p = 1'b1;
    else     rd_a = 1'b1;
    tk(1);
    rd_p = 1'b0;
    rd_a = 1'b0;
  endtask

  initial begin
    vecs[0] = '{par: 1'b0, data: 8'hA5, pbit: 1'b0, odd: 1'b0, exp_data: 8'hA5, exp_perr: 1'b0, exp_ferr: 1'b0};
    vecs[1] = '{par: 1'b1, data: 8'h03, pbit: 1'b0, odd: 1'b0, exp_data: 8'h03, exp_perr: 1'b0, exp_ferr: 1'b0};
    vecs[2] = '{par: 1'b1, data: 8'h03, pbit: 1'b1, odd: 1'b0, exp_data: 8'h03, exp_perr: 1'b1, exp_ferr: 1'b0};
    vecs[3] = '{par: 1'b1, data: 8'h80, pbit: 1'b0, odd: 1'b1, exp_data: 8'h80, exp_perr: 1'b0, exp_ferr: 1'b0};
    vecs[4] = '{par: 1'b1, data: 8'h80, pbit: 1'b0, odd: 1'b0, exp_data: 8'h80, exp_perr: 1'b1, exp_ferr: 1'b0};
    vecs[5] = '{par: 1'b0, data: 8'h00, pbit: 1'b0, odd: 1'b0, exp_data: 8'h00, exp_perr: 1'b0, exp_ferr: 1'b0};

    rst = 1'b0; baud_div = 10'd3; parity_odd = 1'b0;
    rx_a = 1'b1; rd_a = 1'b0; clr_a = 1'b0;
    rx_p = 1'b1; rd_p = 1'b0; clr_p = 1'b0;
    tk(3);
    check("rst_empty", a_empty, 1);
    check("rst_full",  a_full,  0);
    check("rst_count", a_count, 0);
    check("rst_ovr",   a_ovr,   0);
    check("rst_busy",  a_busy,  0);
    check("rst_data",  a_data,  0);
    rst = 1'b1;
    tk(5);

    for (int i = 0; i < 6; i++) begin
      parity_odd = vecs[i].odd;
      send_frame(vecs[i].par, vecs[i].data, vecs[i].pbit, 1'b1);
      tk(8);
      if (vecs[i].par) begin
        check($sformatf("v%0d_count", i), p_count, 1);
        check($sformatf("v%0d_data", i),  p_data,  vecs[i].exp_data);
        check($sformatf("v%0d_perr", i),  p_perr,  vecs[i].exp_perr);
        check($sformatf("v%0d_ferr", i),  p_ferr,  vecs[i].exp_ferr);
        pop(1'b1);
        check($sformatf("v%0d_empty", i), p_empty, 1);
      end else begin
        check($sformatf("v%0d_count", i), a_count, 1);
        check($sformatf("v%0d_data", i),  a_data,  vecs[i].exp_data);
        check($sformatf("v%0d_perr", i),  a_perr,  vecs[i].exp_perr);
        check($sformatf("v%0d_ferr", i),  a_ferr,  vecs[i].exp_ferr);
        pop(1'b0);
        check($sformatf("v%0d_empty", i), a_empty, 1);
      end
    end
    parity_odd = 1'b0;

    // Framing error followed by a held-low line
    send_frame(1'b0, 8'h5A, 1'b0, 1'b0);
    tk(96);
    check("frm_busy_low",  a_busy,  1);
    check("frm_count_low", a_count, 1);
    tk(96);
    rx_a = 1'b1;
    tk(10);
    check("frm_busy_rel", a_busy, 0);
    tk(200);
    check("frm_count", a_count, 1);
    check("frm_data",  a_data,  8'h5A);
    check("frm_ferr",  a_ferr,  1);
    check("frm_perr",  a_perr,  0);
    pop(1'b0);
    check("frm_empty", a_empty, 1);

    // Short glitch: start detect after 3 clocks, rejected at mid-start
    rx_a = 1'b0;
    tk(2);
    check("gl_busy_2clk", a_busy, 0);
    tk(1);
    check("gl_busy_3clk", a_busy, 1);
    tk(17);
    rx_a = 1'b1;
    tk(100);
    check("gl_busy_end", a_busy,  0);
    check("gl_empty",    a_empty, 1);

    // Overrun: nine frames into an eight-entry FIFO
    for (int i = 1; i <= 9; i++) send_frame(1'b0, 8'(i), 1'b0, 1'b1);
    tk(8);
    check("ov_count", a_count, 8);
    check("ov_full",  a_full,  1);
    check("ov_flag",  a_ovr,   1);
    for (int i = 1; i <= 8; i++) begin
      check($sformatf("ov_read%0d", i), a_data, i);
      pop(1'b0);
    end
    check("ov_empty",  a_empty, 1);
    check("ov_hold",   a_data,  8'h08);
    check("ov_sticky", a_ovr,   1);
    clr_a = 1'b1;
    tk(1);
    clr_a = 1'b0;
    check("ov_clr", a_ovr, 0);

    // Reset in the middle of a frame with one entry already queued
    send_frame(1'b0, 8'h77, 1'b0, 1'b1);
    tk(8);
    check("mr_pre_count", a_count, 1);
    rx_a = 1'b0;
    tk(64);
    rx_a = 1'b1;
    tk(100);
    check("mr_pre_busy", a_busy, 1);
    rst = 1'b0;
    #1;
    check("mr_busy",  a_busy,  0);
    check("mr_empty", a_empty, 1);
    check("mr_count", a_count, 0);
    check("mr_data",  a_data,  0);
    check("mr_ferr",  a_ferr,  0);
    tk(2);
    rst = 1'b1;
    tk(700);
    check("mr_no_entry", a_empty, 1);
    send_frame(1'b0, 8'h3C, 1'b0, 1'b1);
    tk(8);
    check("mr_post_count", a_count, 1);
    check("mr_post_data",  a_data,  8'h3C);
    pop(1'b0);
    check("mr_post_empty", a_empty, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
